// File: rtl/regfile_mp.sv
// Multi-port register file for the ID stage: two bypassable combinational read
// ports, two prioritised write-back ports, a busy scoreboard and a post-reset clear sweep.
module regfile_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src_1,
    input  logic [ADDR_W-1:0] src_2,
    output logic [DATA_W-1:0] reg_out_1,
    output logic [DATA_W-1:0] reg_out_2,
    output logic              busy_1,
    output logic              busy_2,
    input  logic              wb_en_0,
    input  logic              wb_en_1,
    input  logic [ADDR_W-1:0] wb_dest_0,
    input  logic [ADDR_W-1:0] wb_dest_1,
    input  logic [DATA_W-1:0] wb_data_0,
    input  logic [DATA_W-1:0] wb_data_1,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_dest,
    output logic              ready
);

    localparam int NUM_REGS = 1 << ADDR_W;

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cnt;
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [DATA_W-1:0]   registers [NUM_REGS];

    // Reserve is applied last so it wins over a same-cycle write-back clear.
    always_comb begin
        busy_next = busy;
        if (wb_en_0) busy_next[wb_dest_0] = 1'b0;
        if (wb_en_1) busy_next[wb_dest_1] = 1'b0;
        if (rsv_en)  busy_next[rsv_dest]  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= CLEAR;
            cnt   <= '0;
            busy  <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (cnt == ADDR_W'(NUM_REGS - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: busy <= busy_next;
                default: state <= CLEAR;
            endcase
        end
    end

    // NOTE: the array has no reset branch so it can map to distributed RAM;
    // the sweep below provides the defined contents instead.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state == CLEAR) begin
                registers[cnt] <= '0;
            end else begin
                if (wb_en_0) registers[wb_dest_0] <= wb_data_0;
                if (wb_en_1) registers[wb_dest_1] <= wb_data_1;
            end
        end
    end

    // NOTE: every output of these comb blocks gets a default first, so no latch is inferred.
    always_comb begin
        reg_out_1 = '0;
        busy_1    = 1'b0;
        if (state == RUN) begin
            busy_1 = busy[src_1];
            if (BYPASS != 0 && wb_en_1 && wb_dest_1 == src_1)
                reg_out_1 = wb_data_1;
            else if (BYPASS != 0 && wb_en_0 && wb_dest_0 == src_1)
                reg_out_1 = wb_data_0;
            else
                reg_out_1 = registers[src_1];
        end
    end

    always_comb begin
        reg_out_2 = '0;
        busy_2    = 1'b0;
        if (state == RUN) begin
            busy_2 = busy[src_2];
            if (BYPASS != 0 && wb_en_1 && wb_dest_1 == src_2)
                reg_out_2 = wb_data_1;
            else if (BYPASS != 0 && wb_en_0 && wb_dest_0 == src_2)
                reg_out_2 = wb_data_0;
            else
                reg_out_2 = registers[src_2];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing and a non-bypassing instance share
// stimulus; expected values are queued by the driver and checked by a monitor.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src_1, src_2, wb_dest_0, wb_dest_1, rsv_dest;
    logic        wb_en_0, wb_en_1, rsv_en;
    logic [31:0] wb_data_0, wb_data_1;

    logic [31:0] reg_out_1, reg_out_2, reg_out_1_nb, reg_out_2_nb;
    logic        busy_1, busy_2, busy_1_nb, busy_2_nb, ready, ready_nb;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(32), .ADDR_W(4), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .src_1(src_1), .src_2(src_2),
        .reg_out_1(reg_out_1), .reg_out_2(reg_out_2), .busy_1(busy_1), .busy_2(busy_2),
        .wb_en_0(wb_en_0), .wb_en_1(wb_en_1), .wb_dest_0(wb_dest_0), .wb_dest_1(wb_dest_1),
        .wb_data_0(wb_data_0), .wb_data_1(wb_data_1), .rsv_en(rsv_en), .rsv_dest(rsv_dest),
        .ready(ready)
    );

    regfile_mp #(.DATA_W(32), .ADDR_W(4), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .src_1(src_1), .src_2(src_2),
        .reg_out_1(reg_out_1_nb), .reg_out_2(reg_out_2_nb), .busy_1(busy_1_nb), .busy_2(busy_2_nb),
        .wb_en_0(wb_en_0), .wb_en_1(wb_en_1), .wb_dest_0(wb_dest_0), .wb_dest_1(wb_dest_1),
        .wb_data_0(wb_data_0), .wb_data_1(wb_data_1), .rsv_en(rsv_en), .rsv_dest(rsv_dest),
        .ready(ready_nb)
    );

    typedef enum {S_R1, S_R2, S_B1, S_B2, S_RDY, S_R1N, S_R2N, S_B1N, S_RDYN} sel_e;
    typedef struct {
        sel_e        sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic logic [31:0] actual(input sel_e sel);
        case (sel)
            S_R1:    return reg_out_1;
            S_R2:    return reg_out_2;
            S_B1:    return {31'd0, busy_1};
            S_B2:    return {31'd0, busy_2};
            S_RDY:   return {31'd0, ready};
            S_R1N:   return reg_out_1_nb;
            S_R2N:   return reg_out_2_nb;
            S_B1N:   return {31'd0, busy_1_nb};
            default: return {31'd0, ready_nb};
        endcase
    endfunction

    // Monitor: every queued expectation belongs to the current cycle and is checked mid-cycle.
    initial begin
        exp_t e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = actual(e.sel);
                tests++;
                if (act !== e.exp) begin
                    fails++;
                    $display("FAIL %s (%s): got %h, expected %h", e.name, e.sel.name(), act, e.exp);
                end
            end
        end
    end

    task automatic push(input sel_e sel, input logic [31:0] exp, input string name);
        exp_t e;
        e.sel = sel; e.exp = exp; e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_en_0 = 1'b0; wb_en_1 = 1'b0; rsv_en = 1'b0;
    endtask

    // Sweep of 16 edges after rst release; optionally attempts writes/reserves meanwhile.
    task automatic sweep(input string name, input bit attempt);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (attempt && i < 16) begin
                wb_en_0 = 1'b1; wb_dest_0 = 4'd0; wb_data_0 = 32'hDEAD_0000 | i;
                rsv_en  = 1'b1; rsv_dest  = 4'd4;
            end else begin
                idle_inputs();
            end
            src_1 = 4'd0;
            src_2 = 4'(i);
            push(S_RDY,  {31'd0, i == 16}, name);
            push(S_RDYN, {31'd0, i == 16}, name);
            if (i < 16) begin
                push(S_R1, 32'd0, {name, " forced read"});
                push(S_B2, 32'd0, {name, " forced busy"});
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        src_1 = '0; src_2 = '0; wb_dest_0 = '0; wb_dest_1 = '0; rsv_dest = '0;
        wb_data_0 = '0; wb_data_1 = '0;
        idle_inputs();

        repeat (3) step();
        push(S_RDY, 32'd0, "reset ready");
        push(S_R1,  32'd0, "reset read");
        push(S_B1,  32'd0, "reset busy");
        rst = 1'b1;
        sweep("clear sweep", 1'b0);

        for (int i = 0; i < 16; i++) begin
            step();
            src_1 = 4'(i); src_2 = 4'(15 - i);
            push(S_R1,  32'd0, "post-clear read1");
            push(S_R2N, 32'd0, "post-clear read2");
            push(S_B1,  32'd0, "post-clear busy1");
        end

        // Bypass vs non-bypass on register 3
        step(); wb_en_0 = 1'b1; wb_dest_0 = 4'd3; wb_data_0 = 32'h11;
        step(); wb_data_0 = 32'h22; src_1 = 4'd3;
        push(S_R1,  32'h22, "bypass same-cycle");
        push(S_R1N, 32'h11, "no-bypass same-cycle");
        step(); idle_inputs();
        push(S_R1,  32'h22, "bypass next-cycle");
        push(S_R1N, 32'h22, "no-bypass next-cycle");

        // Dual write to the same register: port 1 wins
        step();
        wb_en_0 = 1'b1; wb_dest_0 = 4'd5; wb_data_0 = 32'hAAAA_0000;
        wb_en_1 = 1'b1; wb_dest_1 = 4'd5; wb_data_1 = 32'h1234_5678;
        src_2 = 4'd5;
        push(S_R2,  32'h1234_5678, "dual bypass prio");
        push(S_R2N, 32'h0,         "dual no-bypass old");
        step(); idle_inputs();
        push(S_R2,  32'h1234_5678, "dual conflict result");
        push(S_R2N, 32'h1234_5678, "dual conflict result nb");

        // Independent writes on both ports
        step();
        wb_en_0 = 1'b1; wb_dest_0 = 4'd9;  wb_data_0 = 32'h99;
        wb_en_1 = 1'b1; wb_dest_1 = 4'd10; wb_data_1 = 32'hA0;
        src_1 = 4'd9; src_2 = 4'd10;
        push(S_R1, 32'h99, "two-port bypass p0");
        push(S_R2, 32'hA0, "two-port bypass p1");
        step(); idle_inputs();
        push(S_R1N, 32'h99, "two-port write p0");
        push(S_R2N, 32'hA0, "two-port write p1");

        // Scoreboard on register 7
        step(); rsv_en = 1'b1; rsv_dest = 4'd7; src_1 = 4'd7;
        push(S_B1, 32'd0, "reserve not yet visible");
        step(); idle_inputs();
        push(S_B1, 32'd1, "reserve set");
        step();
        rsv_en = 1'b1; rsv_dest = 4'd7;
        wb_en_0 = 1'b1; wb_dest_0 = 4'd7; wb_data_0 = 32'h77;
        push(S_B1,  32'd1,  "collision cycle busy");
        push(S_R1,  32'h77, "collision bypass");
        push(S_R1N, 32'h0,  "collision no-bypass");
        step(); idle_inputs();
        push(S_B1,  32'd1,  "reserve wins collision");
        push(S_B1N, 32'd1,  "reserve wins collision nb");
        push(S_R1N, 32'h77, "collision data written");
        step(); wb_en_1 = 1'b1; wb_dest_1 = 4'd7; wb_data_1 = 32'h88;
        push(S_B1, 32'd1, "busy clear not bypassed");
        step(); idle_inputs();
        push(S_B1,  32'd0,  "write-back clears busy");
        push(S_R1N, 32'h88, "write-back data");

        step(); rsv_en = 1'b1; rsv_dest = 4'd12;
        step(); idle_inputs(); src_2 = 4'd12;
        push(S_B2, 32'd1, "busy2 reserve");

        // Reset from RUN, then a mid-sweep reset at sweep cycle 9 with writes attempted
        step(); rst = 1'b0; src_1 = 4'd9;
        step(); rst = 1'b1;
        push(S_RDY, 32'd0, "run reset ready");
        push(S_R1,  32'd0, "run reset read");
        for (int i = 1; i <= 9; i++) begin
            step();
            wb_en_0 = 1'b1; wb_dest_0 = 4'd0; wb_data_0 = 32'hBEEF_0000 | i;
            rsv_en  = 1'b1; rsv_dest  = 4'd4;
            push(S_RDY, 32'd0, "partial sweep ready");
        end
        rst = 1'b0;
        step(); rst = 1'b1;
        push(S_RDY, 32'd0, "mid-sweep reset ready");
        sweep("restarted sweep", 1'b1);

        step(); src_1 = 4'd0; src_2 = 4'd4;
        push(S_R1,  32'd0, "sweep write ignored");
        push(S_R1N, 32'd0, "sweep write ignored nb");
        push(S_B2,  32'd0, "sweep reserve ignored");
        push(S_B1,  32'd0, "busy reg0 after sweep");
        step(); src_1 = 4'd9; src_2 = 4'd12;
        push(S_R1, 32'd0, "reg9 re-cleared");
        push(S_B2, 32'd0, "busy12 reset");

        repeat (2) @(negedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard drain: %0d left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
